// File: rtl/load_store_unit_if.sv
// Memory-side types and the execute-stage request/response bundle
// shared by the load/store unit and its requester.
package lsu_pkg;
  typedef enum logic {
    MEM_READ_EN  = 1'b0,
    MEM_WRITE_EN = 1'b1
  } mem_en_t;

  typedef struct packed {
    logic        mem_enable;
    mem_en_t     mem_en;
    logic [31:0] address;
    logic [31:0] data_in;
  } data_memory_interface_t;
endpackage

interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_funct3,
    output req_address, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_misaligned, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_address, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output resp_misaligned, resp_fault
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit; sub-word stores are done as
// read-modify-write because data_memory only writes whole words.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS    = 256,
  parameter bit CHECK_BOUNDS = 1'b1
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  lsu_if.slave                   bus,
  output data_memory_interface_t o_mem_sig,
  input  logic [31:0]            i_mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

  state_t      r_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_mem_addr;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_fault;

  state_t      w_next;
  logic        w_accept;
  logic        w_mis;
  logic        w_bad_f3;
  logic        w_oob;
  logic [2:0]  w_f3;
  logic [31:0] w_addr;
  logic [31:0] w_shift;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merge;

  assign w_f3     = bus.req_funct3;
  assign w_addr   = bus.req_address;
  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  always_comb begin
    w_mis = 1'b0;
    if (w_f3 == 3'd2)
      w_mis = (w_addr[1:0] != 2'b00);
    else if (w_f3 == 3'd1 || (!bus.req_write && w_f3 == 3'd5))
      w_mis = w_addr[0];
  end

  assign w_bad_f3 = bus.req_write ? (w_f3 > 3'd2)
                  : (w_f3 == 3'd3 || w_f3 == 3'd6 || w_f3 == 3'd7);
  assign w_oob    = CHECK_BOUNDS && (w_addr[31:2] >= LP_WORDS);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mis || w_bad_f3 || w_oob)
            w_next = S_RESP;
          else if (bus.req_write && w_f3 == 3'd2)
            w_next = S_WRITE;
          else
            w_next = S_READ;
        end
      end
      S_READ:  w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Little-endian lane extraction straight from the memory read port
  assign w_shift = i_mem_rdata >> {r_off, 3'b000};
  assign w_half  = r_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    w_load = i_mem_rdata;
    unique case (r_funct3)
      3'd0:    w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'd4:    w_load = {24'd0, w_shift[7:0]};
      3'd1:    w_load = {{16{w_half[15]}}, w_half};
      3'd5:    w_load = {16'd0, w_half};
      default: w_load = i_mem_rdata;
    endcase
  end

  always_comb begin
    w_merge = r_wdata;
    unique case (r_funct3[1:0])
      2'b00: begin
        w_merge = r_word;
        w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
      end
      2'b01: begin
        w_merge = r_word;
        w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
      end
      default: w_merge = r_wdata;
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_write    <= 1'b0;
      r_funct3   <= 3'd0;
      r_off      <= 2'd0;
      r_wdata    <= 32'd0;
      r_word     <= 32'd0;
      r_mem_addr <= 32'd0;
      r_rdata    <= 32'd0;
      r_mis      <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= w_f3;
            r_off    <= w_addr[1:0];
            r_wdata  <= bus.req_wdata;
            if (w_next == S_RESP) begin
              r_rdata <= 32'd0;
              r_mis   <= w_mis;
              r_fault <= !w_mis;
            end else begin
              r_mem_addr <= {w_addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          r_word <= i_mem_rdata;
          if (!r_write) begin
            r_rdata <= w_load;
            r_mis   <= 1'b0;
            r_fault <= 1'b0;
          end
        end
        S_WRITE: begin
          r_rdata <= 32'd0;
          r_mis   <= 1'b0;
          r_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Enable is decoded from state so an async reset kills it at once
  always_comb begin
    o_mem_sig         = '0;
    o_mem_sig.address = r_mem_addr;
    unique case (r_state)
      S_READ: begin
        o_mem_sig.mem_enable = 1'b1;
      end
      S_WRITE: begin
        o_mem_sig.mem_enable = 1'b1;
        o_mem_sig.mem_en     = MEM_WRITE_EN;
        o_mem_sig.data_in    = w_merge;
      end
      default: ;
    endcase
  end

  assign bus.req_ready       = (r_state == S_IDLE);
  assign bus.resp_valid      = (r_state == S_RESP);
  assign bus.resp_rdata      = r_rdata;
  assign bus.resp_misaligned = r_mis;
  assign bus.resp_fault      = r_fault;

endmodule
